ps2_pad_responder: RTL and testbench

- Controller-side (responder) end of the PS2 gamepad polling bus. Emulates an analog DualShock pad.
- Answers host poll frames (0x01, 0x42, 0x00…) with a 9-byte reply built from board switches or stick values.
- Used for on-board loopback tests of the host poller and for driving the game without a physical pad.
- The host-side bus signals are slow; all bus inputs are synchronized into CLK_40M and handled through edge detection.

---
 rtl/ps2_pad_responder.sv | 178 +++++++++++++++++
 tb/tb_ps2_pad_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_pad_responder.sv
// rtl/ps2_pad_responder.sv - PS2 DualShock pad emulator answering host poll frames
module ps2_pad_responder #(
    parameter logic [7:0] PAD_ID    = 8'h73,
    parameter int         ACK_DELAY = 160,
    parameter int         ACK_LEN   = 120
) (
    input  logic       CLK_40M,
    input  logic       rst,
    input  logic       scs,
    input  logic       sclk,
    input  logic       sdo,
    input  logic [15:0] btn_n,
    input  logic [7:0] stick_rx,
    input  logic [7:0] stick_ry,
    input  logic [7:0] stick_lx,
    input  logic [7:0] stick_ly,
    output logic       di,
    output logic       ack_n,
    output logic       busy,
    output logic       poll_done,
    output logic       frame_err
);

    localparam int            TW    = $clog2(ACK_DELAY + ACK_LEN + 1);
    localparam logic [TW-1:0] T_ON  = TW'(ACK_DELAY);
    localparam logic [TW-1:0] T_OFF = TW'(ACK_DELAY + ACK_LEN);

    typedef enum logic [2:0] {IDLE, SHIFT, ACK, IGNORE, DONE} state_t;

    state_t          state, state_nx;
    logic            scs_m, scs_s, scs_p, sclk_m, sclk_s, sclk_p, sdo_m, sdo_s;
    logic            scs_fall, scs_rise, sclk_fall, sclk_rise;
    logic [8:0][7:0] reply, snap;
    logic            snap_load;
    logic [2:0]      bit_cnt, bit_nx;
    logic [3:0]      byte_cnt, byte_nx, byte_inc;
    logic [7:0]      rx_sh, rx_nx, rx_full;
    logic [TW-1:0]   timer, timer_nx, t_inc;
    logic            di_nx, ack_nx, busy_nx, poll_nx, err_nx;

    always_ff @(posedge CLK_40M or posedge rst) begin
        if (rst) begin
            {scs_m, scs_s, scs_p}    <= 3'b111;
            {sclk_m, sclk_s, sclk_p} <= 3'b111;
            {sdo_m, sdo_s}           <= 2'b11;
        end else begin
            {scs_m, scs_s, scs_p}    <= {scs, scs_m, scs_s};
            {sclk_m, sclk_s, sclk_p} <= {sclk, sclk_m, sclk_s};
            {sdo_m, sdo_s}           <= {sdo, sdo_m};
        end
    end

    assign scs_fall  = scs_p & ~scs_s;
    assign scs_rise  = ~scs_p & scs_s;
    assign sclk_fall = sclk_p & ~sclk_s;
    assign sclk_rise = ~sclk_p & sclk_s;

    // Byte 0 of the reply lives in the low slot so reply[byte_cnt] walks the frame in order.
    assign snap = {stick_ly, stick_lx, stick_ry, stick_rx, btn_n[15:8], btn_n[7:0],
                   8'h5A, PAD_ID, 8'hFF};

    always_comb begin
        state_nx  = state;
        bit_nx    = bit_cnt;
        byte_nx   = byte_cnt;
        rx_nx     = rx_sh;
        timer_nx  = timer;
        di_nx     = di;
        ack_nx    = ack_n;
        busy_nx   = busy;
        poll_nx   = 1'b0;
        err_nx    = 1'b0;
        snap_load = 1'b0;
        t_inc     = timer + 1'b1;
        byte_inc  = byte_cnt + 4'd1;
        rx_full   = {sdo_s, rx_sh[6:0]};
        case (state)
            IDLE: begin
                di_nx  = 1'b1;
                ack_nx = 1'b1;
                if (scs_fall) begin
                    snap_load = 1'b1;
                    byte_nx   = 4'd0;
                    bit_nx    = 3'd0;
                    busy_nx   = 1'b1;
                    di_nx     = snap[0][0];
                    state_nx  = SHIFT;
                end
            end
            SHIFT, ACK: begin
                if (scs_rise) begin
                    ack_nx   = 1'b1;
                    di_nx    = 1'b1;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (state == SHIFT) begin
                    if (sclk_fall && bit_cnt != 3'd0) begin
                        di_nx = reply[byte_cnt][bit_cnt];
                    end else if (sclk_rise) begin
                        rx_nx[bit_cnt] = sdo_s;
                        bit_nx         = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if ((byte_cnt == 4'd0 && rx_full != 8'h01) ||
                                (byte_cnt == 4'd1 && rx_full != 8'h42)) begin
                                err_nx   = 1'b1;
                                di_nx    = 1'b1;
                                state_nx = IGNORE;
                            end else if (byte_cnt == 4'd8) begin
                                di_nx    = 1'b1;
                                state_nx = DONE;
                            end else begin
                                timer_nx = 1;
                                state_nx = ACK;
                            end
                        end
                    end
                end else begin
                    // timer counts cycles since the byte-completing edge; ack_n follows one cycle later
                    timer_nx = t_inc;
                    ack_nx   = !(t_inc >= T_ON && t_inc < T_OFF);
                    if (t_inc == T_OFF) begin
                        ack_nx   = 1'b1;
                        byte_nx  = byte_inc;
                        di_nx    = reply[byte_inc][0];
                        state_nx = SHIFT;
                    end
                end
            end
            IGNORE: begin
                di_nx  = 1'b1;
                ack_nx = 1'b1;
                if (scs_rise) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            DONE: begin
                di_nx = 1'b1;
                if (scs_rise) begin
                    poll_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK_40M or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 4'd0;
            rx_sh     <= 8'd0;
            timer     <= '0;
            reply     <= '1;
            di        <= 1'b1;
            ack_n     <= 1'b1;
            busy      <= 1'b0;
            poll_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_nx;
            byte_cnt  <= byte_nx;
            rx_sh     <= rx_nx;
            timer     <= timer_nx;
            if (snap_load) reply <= snap;
            di        <= di_nx;
            ack_n     <= ack_nx;
            busy      <= busy_nx;
            poll_done <= poll_nx;
            frame_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_ps2_pad_responder.sv
// tb/tb_ps2_pad_responder.sv - randomized host-side poller checking the pad responder
module tb_ps2_pad_responder;

    localparam int D    = 12;
    localparam int L    = 8;
    localparam int HALF = 26;
    localparam logic [7:0] ID = 8'h73;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scs = 1'b1, sclk = 1'b1, sdo = 1'b1;
    logic [15:0] btn_n = 16'hFFFF;
    logic [7:0] rx = 8'h80, ry = 8'h80, lx = 8'h80, ly = 8'h80;
    logic di, ack_n, busy, poll_done, frame_err;

    always #5 clk = ~clk;

    ps2_pad_responder #(.PAD_ID(ID), .ACK_DELAY(D), .ACK_LEN(L)) dut (
        .CLK_40M(clk), .rst(rst), .scs(scs), .sclk(sclk), .sdo(sdo), .btn_n(btn_n),
        .stick_rx(rx), .stick_ry(ry), .stick_lx(lx), .stick_ly(ly),
        .di(di), .ack_n(ack_n), .busy(busy), .poll_done(poll_done), .frame_err(frame_err)
    );

    int nvec = 0;
    int nbad = 0;
    logic [7:0] cmd [9];
    logic [7:0] got [9];
    logic [7:0] exp_b [9];
    int abort_byte = -1, abort_bit = 0, chg_byte = -1;
    logic [15:0] chg_val = 16'hFFFF;

    // Bus monitor sampled on the falling clock edge.
    logic prev_sclk = 1'b1, prev_ack = 1'b1;
    int since = 0, cur_len = 0, poll_cnt = 0, err_cnt = 0;
    int ack_dly [$];
    int ack_len [$];

    always @(negedge clk) begin
        since     <= (sclk && !prev_sclk) ? 0 : since + 1;
        prev_sclk <= sclk;
        prev_ack  <= ack_n;
        if (!ack_n && prev_ack) begin
            ack_dly.push_back(since);
            cur_len <= 1;
        end else if (!ack_n) begin
            cur_len <= cur_len + 1;
        end
        if (ack_n && !prev_ack) ack_len.push_back(cur_len);
        if (poll_done === 1'b1) poll_cnt <= poll_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_poll_cmd();
        cmd[0] = 8'h01;
        cmd[1] = 8'h42;
        for (int i = 2; i < 9; i++) cmd[i] = 8'h00;
    endtask

    task automatic randomize_pad();
        btn_n = 16'($urandom);
        rx = 8'($urandom); ry = 8'($urandom); lx = 8'($urandom); ly = 8'($urandom);
    endtask

    task automatic run_frame(input string name);
        int a0, l0, p0, e0, bad_at, nbytes, nacks_exp;
        bit stop;
        a0 = ack_dly.size(); l0 = ack_len.size(); p0 = poll_cnt; e0 = err_cnt;
        exp_b[0] = 8'hFF; exp_b[1] = ID; exp_b[2] = 8'h5A;
        exp_b[3] = btn_n[7:0]; exp_b[4] = btn_n[15:8];
        exp_b[5] = rx; exp_b[6] = ry; exp_b[7] = lx; exp_b[8] = ly;
        bad_at = (cmd[0] != 8'h01) ? 0 : (cmd[1] != 8'h42) ? 1 : 9;
        stop = 1'b0;
        scs = 1'b0;
        cyc(10);
        for (int by = 0; by < 9 && !stop; by++) begin
            for (int bi = 0; bi < 8; bi++) begin
                if (by == abort_byte && bi == abort_bit) begin
                    stop = 1'b1;
                    break;
                end
                sdo  = cmd[by][bi];
                sclk = 1'b0;
                cyc(HALF);
                got[by][bi] = di;
                sclk = 1'b1;
                cyc(HALF);
            end
            if (by == chg_byte) btn_n = chg_val;
        end
        if (!stop) begin
            nvec++;
            if (busy !== 1'b1) begin
                nbad++;
                $display("FAIL %s busy_in_frame: got %b want 1", name, busy);
            end
        end
        scs = 1'b1;
        cyc(10);
        nbytes    = stop ? abort_byte : 9;
        nacks_exp = stop ? abort_byte : (bad_at < 9 ? bad_at : 8);
        for (int by = 0; by < nbytes; by++) begin
            nvec++;
            if (got[by] !== ((by > bad_at) ? 8'hFF : exp_b[by])) begin
                nbad++;
                $display("FAIL %s di_byte%0d: got %h want %h", name, by, got[by],
                         (by > bad_at) ? 8'hFF : exp_b[by]);
            end
        end
        nvec++;
        if (ack_dly.size() - a0 != nacks_exp) begin
            nbad++;
            $display("FAIL %s ack_count: got %0d want %0d", name, ack_dly.size() - a0, nacks_exp);
        end
        for (int i = a0; i < ack_dly.size(); i++) begin
            nvec++;
            if (ack_dly[i] < D || ack_dly[i] > D + 3) begin
                nbad++;
                $display("FAIL %s ack_delay%0d: got %0d want %0d..%0d", name, i - a0, ack_dly[i], D, D + 3);
            end
        end
        for (int i = l0; i < ack_len.size(); i++) begin
            nvec++;
            if (ack_len[i] != L) begin
                nbad++;
                $display("FAIL %s ack_len%0d: got %0d want %0d", name, i - l0, ack_len[i], L);
            end
        end
        nvec++;
        if (poll_cnt - p0 != ((!stop && bad_at == 9) ? 1 : 0)) begin
            nbad++;
            $display("FAIL %s poll_done_count: got %0d want %0d", name, poll_cnt - p0,
                     (!stop && bad_at == 9) ? 1 : 0);
        end
        nvec++;
        if (err_cnt - e0 != ((stop || bad_at < 9) ? 1 : 0)) begin
            nbad++;
            $display("FAIL %s frame_err_count: got %0d want %0d", name, err_cnt - e0,
                     (stop || bad_at < 9) ? 1 : 0);
        end
        nvec++;
        if ({busy, ack_n, di} !== 3'b011) begin
            nbad++;
            $display("FAIL %s idle_outputs: got busy,ack_n,di=%b want 011", name, {busy, ack_n, di});
        end
    endtask

    task automatic test_reset();
        cyc(3);
        nvec++;
        if ({di, ack_n, busy, poll_done, frame_err} !== 5'b11000) begin
            nbad++;
            $display("FAIL reset_outputs: got %b want 11000", {di, ack_n, busy, poll_done, frame_err});
        end
        rst = 1'b0;
        cyc(5);
    endtask

    task automatic test_valid_poll();
        set_poll_cmd();
        btn_n = 16'hDFFF; rx = 8'h80; ry = 8'h7F; lx = 8'h00; ly = 8'hFF;
        run_frame("valid_poll");
    endtask

    task automatic test_bad_header();
        set_poll_cmd();
        cmd[0] = 8'h81;
        randomize_pad();
        run_frame("bad_header");
    endtask

    task automatic test_bad_address();
        set_poll_cmd();
        cmd[1] = 8'h43;
        randomize_pad();
        run_frame("bad_address");
    endtask

    task automatic test_abort();
        set_poll_cmd();
        randomize_pad();
        abort_byte = 4; abort_bit = 5;
        run_frame("abort");
        abort_byte = -1;
        randomize_pad();
        run_frame("after_abort");
    endtask

    task automatic test_snapshot();
        set_poll_cmd();
        btn_n = 16'hFFFF;
        chg_byte = 2; chg_val = 16'h7FFF;
        run_frame("snapshot_cur");
        chg_byte = -1;
        nvec++;
        if (got[4] !== 8'hFF) begin
            nbad++;
            $display("FAIL snapshot_cur_byte4: got %h want ff", got[4]);
        end
        run_frame("snapshot_next");
        nvec++;
        if (got[4] !== 8'h7F) begin
            nbad++;
            $display("FAIL snapshot_next_byte4: got %h want 7f", got[4]);
        end
    endtask

    task automatic test_reset_mid_ack();
        int waited;
        scs = 1'b0;
        cyc(10);
        for (int bi = 0; bi < 8; bi++) begin
            sdo  = bi == 0;
            sclk = 1'b0;
            cyc(HALF);
            sclk = 1'b1;
            cyc(1);
        end
        waited = 0;
        while (ack_n !== 1'b0 && waited < 100) begin
            cyc(1);
            waited++;
        end
        nvec++;
        if (ack_n !== 1'b0) begin
            nbad++;
            $display("FAIL reset_mid_ack_reach: got ack_n=%b want 0 within 100 cycles", ack_n);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({ack_n, di, busy} !== 3'b110) begin
            nbad++;
            $display("FAIL reset_mid_ack_async: got ack_n,di,busy=%b want 110", {ack_n, di, busy});
        end
        sclk = 1'b1; scs = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        set_poll_cmd();
        randomize_pad();
        run_frame("after_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            set_poll_cmd();
            for (int i = 2; i < 9; i++) cmd[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmd[$urandom_range(0, 1)] = 8'($urandom_range(2, 255));
            randomize_pad();
            run_frame("random");
        end
    endtask

    initial begin
        test_reset();
        test_valid_poll();
        test_bad_header();
        test_bad_address();
        test_abort();
        test_snapshot();
        test_reset_mid_ack();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
